// File: rtl/lfsr_pkg.sv
// ============================================================================
// Module      : lfsr_pkg
// Description : Shared FSM state type and default tap/seed constants for the
//               LFSR generator family.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lfsr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } lfsr_state_t;

    // Fibonacci left-shift masks: bit i set feeds state bit i into the XOR
    localparam logic [7:0]  c_taps_8  = 8'h8E;
    localparam logic [7:0]  c_seed_8  = 8'h80;
    localparam logic [15:0] c_taps_16 = 16'hB400;
    localparam logic [15:0] c_seed_16 = 16'h8000;
    localparam logic [31:0] c_taps_32 = 32'h8020_0003;
    localparam logic [31:0] c_seed_32 = 32'h8000_0000;

endpackage

`default_nettype wire

// File: rtl/lfsr_step.sv
// ============================================================================
// Module      : lfsr_step
// Description : One combinational Fibonacci LFSR shift (left shift, XOR feedback).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = c_taps_8
) (
    input  logic [WIDTH-1:0] i_s,
    output logic [WIDTH-1:0] o_s
);

    logic w_fb;

    assign w_fb = ^(i_s & TAPS);
    assign o_s  = {i_s[WIDTH-2:0], w_fb};

endmodule

`default_nettype wire

// File: rtl/lfsr_gen.sv
// ============================================================================
// Module      : lfsr_gen
// Description : Multi-step Fibonacci LFSR with seed handshake and sticky
//               zero-seed flag. Optional wrap detection via LFSR_GEN_WRAP_DET_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = c_taps_8,
    parameter logic [WIDTH-1:0] SEED  = c_seed_8,
    parameter int               STEPS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             seed_valid,
    input  logic [WIDTH-1:0] seed_in,
    output logic             seed_ready,
    output logic [WIDTH-1:0] out_s,
    output logic             out_valid,
    output logic             seed_err
`ifdef LFSR_GEN_WRAP_DET_EN
    ,
    output logic             wrap
`endif
);

    lfsr_state_t      r_state;
    lfsr_state_t      w_state_nxt;
    logic [WIDTH-1:0] r_s;
    logic             r_seed_ready;
    logic             r_seed_err;
    logic             w_hs;
    logic             w_seed_zero;
    logic [WIDTH-1:0] w_load;
    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_chain [0:STEPS];

    assign w_hs        = seed_valid & r_seed_ready;
    assign w_seed_zero = (seed_in == '0);
    assign w_load      = w_seed_zero ? SEED : seed_in;

    assign w_chain[0] = r_s;
    generate
        for (genvar gi = 0; gi < STEPS; gi++) begin : g_steps
            lfsr_step #(
                .WIDTH (WIDTH),
                .TAPS  (TAPS)
            ) u_step (
                .i_s (w_chain[gi]),
                .o_s (w_chain[gi+1])
            );
        end
    endgenerate

    // Fall back to SEED so a degenerate tap mask can never park the register at zero
    assign w_step = (w_chain[STEPS] == '0) ? SEED : w_chain[STEPS];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (en || w_hs)   w_state_nxt = ST_RUN;
            ST_RUN:  if (!en && !w_hs) w_state_nxt = ST_HOLD;
            ST_HOLD: if (en || w_hs)   w_state_nxt = ST_RUN;
            default:                   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_s          <= SEED;
            r_seed_ready <= 1'b1;
            r_seed_err   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_seed_ready <= ~w_hs;
            if (w_hs) begin
                r_s        <= w_load;
                r_seed_err <= w_seed_zero;
            end else if (en) begin
                r_s <= w_step;
            end
        end
    end

    assign out_s      = r_s;
    assign out_valid  = (r_state != ST_IDLE);
    assign seed_ready = r_seed_ready;
    assign seed_err   = r_seed_err;

`ifdef LFSR_GEN_WRAP_DET_EN
    localparam logic [WIDTH:0] c_period = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH:0] c_steps  = (WIDTH+1)'(STEPS);

    logic [WIDTH-1:0] r_cnt;
    logic             r_wrap;
    logic [WIDTH:0]   w_cnt_sum;

    assign w_cnt_sum = {1'b0, r_cnt} + c_steps;

    // Counter runs modulo the maximal period; any seed load restarts it
    always_ff @(posedge clk) begin
        if (rst || w_hs) begin
            r_cnt  <= '0;
            r_wrap <= 1'b0;
        end else if (en) begin
            if (w_cnt_sum >= c_period) begin
                r_cnt  <= WIDTH'(w_cnt_sum - c_period);
                r_wrap <= 1'b1;
            end else begin
                r_cnt  <= WIDTH'(w_cnt_sum);
                r_wrap <= 1'b0;
            end
        end else begin
            r_wrap <= 1'b0;
        end
    end

    assign wrap = r_wrap;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lfsr_gen.sv
// ============================================================================
// Module      : tb_lfsr_gen
// Description : Self-checking bench for lfsr_gen (default params and STEPS=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lfsr_gen;

    localparam int TAPS_REF = 'h8E;
    localparam int SEED_REF = 'h80;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       seed_valid = 1'b0;
    logic [7:0] seed_in = 8'h00;
    logic       seed_ready;
    logic [7:0] out_s;
    logic       out_valid;
    logic       seed_err;
    logic       en4 = 1'b0;
    logic       seed_ready4;
    logic [7:0] out_s4;
    logic       out_valid4;
    logic       seed_err4;
`ifdef LFSR_GEN_WRAP_DET_EN
    logic       wrap;
    logic       wrap4;
`endif

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    logic [7:0] m_s = 8'h80;
    logic       m_valid = 1'b0;
    logic       m_ready = 1'b1;
    logic       m_err = 1'b0;
    logic       m_wrap = 1'b0;
    int         m_cnt = 0;
    logic [7:0] m4_s = 8'h80;
    logic       m4_valid = 1'b0;

    always #5 clk = ~clk;

    lfsr_gen dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .seed_valid (seed_valid),
        .seed_in    (seed_in),
        .seed_ready (seed_ready),
        .out_s      (out_s),
        .out_valid  (out_valid),
        .seed_err   (seed_err)
`ifdef LFSR_GEN_WRAP_DET_EN
        ,
        .wrap       (wrap)
`endif
    );

    lfsr_gen #(.STEPS(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .en         (en4),
        .seed_valid (1'b0),
        .seed_in    (8'h00),
        .seed_ready (seed_ready4),
        .out_s      (out_s4),
        .out_valid  (out_valid4),
        .seed_err   (seed_err4)
`ifdef LFSR_GEN_WRAP_DET_EN
        ,
        .wrap       (wrap4)
`endif
    );

    // Feedback parity counted tap by tap, new value built arithmetically
    function automatic logic [7:0] model_shift(input logic [7:0] s);
        int ones = 0;
        for (int i = 0; i < 8; i++)
            if ((((TAPS_REF >> i) & 1) == 1) && (((int'(s) >> i) & 1) == 1)) ones++;
        return 8'((int'(s) * 2 + ones % 2) % 256);
    endfunction

    // Advance the model with the inputs presented this cycle, then clock the DUTs
    task automatic tick();
        bit hs;
        if (rst) begin
            m_s = 8'(SEED_REF); m_valid = 0; m_ready = 1; m_err = 0; m_cnt = 0; m_wrap = 0;
            m4_s = 8'(SEED_REF); m4_valid = 0;
        end else begin
            hs = seed_valid && m_ready;
            m_wrap = 0;
            if (hs) begin
                m_s   = (seed_in == 8'h00) ? 8'(SEED_REF) : seed_in;
                m_err = (seed_in == 8'h00);
                m_cnt = 0;
            end else if (en) begin
                m_s = model_shift(m_s);
                m_cnt++;
                if (m_cnt == 255) begin m_wrap = 1; m_cnt = 0; end
            end
            if (hs || en) m_valid = 1;
            m_ready = !hs;
            if (en4) begin
                for (int k = 0; k < 4; k++) m4_s = model_shift(m4_s);
                m4_valid = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; en = 1; seed_valid = 1; seed_in = 8'h55; en4 = 1;
        tick(); tick();
        n_vec++; if (out_s !== 8'h80) begin n_err++; $display("FAIL reset out_s: got %h expected 80", out_s); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset out_valid: got %b expected 0", out_valid); end
        n_vec++; if (seed_ready !== 1'b1) begin n_err++; $display("FAIL reset seed_ready: got %b expected 1", seed_ready); end
        n_vec++; if (seed_err !== 1'b0) begin n_err++; $display("FAIL reset seed_err: got %b expected 0", seed_err); end
        n_vec++; if (out_s4 !== 8'h80) begin n_err++; $display("FAIL reset out_s4: got %h expected 80", out_s4); end
`ifdef LFSR_GEN_WRAP_DET_EN
        n_vec++; if (wrap !== 1'b0) begin n_err++; $display("FAIL reset wrap: got %b expected 0", wrap); end
`endif
        rst = 0; en = 0; seed_valid = 0; en4 = 0;
    endtask

    task automatic test_run5();
        rst = 1; tick(); rst = 0;
        en = 1;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_vec++; if (out_s !== m_s) begin n_err++; $display("FAIL run5 out_s cycle %0d: got %h expected %h", c, out_s, m_s); end
            n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL run5 out_valid cycle %0d: got %b expected 1", c, out_valid); end
        end
        en = 0;
    endtask

    task automatic test_wrap();
        int pulses = 0;
        rst = 1; tick(); rst = 0;
        en = 1;
        for (int c = 0; c < 255; c++) begin
            tick();
            n_vec++; if (out_s === 8'h00) begin n_err++; $display("FAIL wrap zero-state cycle %0d: got %h expected non-zero", c, out_s); end
`ifdef LFSR_GEN_WRAP_DET_EN
            if (wrap === 1'b1) pulses++;
`endif
        end
        en = 0;
        n_vec++; if (out_s !== 8'h80) begin n_err++; $display("FAIL wrap period: got %h expected 80", out_s); end
`ifdef LFSR_GEN_WRAP_DET_EN
        n_vec++; if (pulses != 1) begin n_err++; $display("FAIL wrap pulses: got %0d expected 1", pulses); end
`endif
    endtask

    task automatic test_seed_err();
        rst = 1; tick(); rst = 0;
        seed_valid = 1; seed_in = 8'h00;
        tick();
        seed_valid = 0;
        n_vec++; if (out_s !== 8'h80) begin n_err++; $display("FAIL seed0 out_s: got %h expected 80", out_s); end
        n_vec++; if (seed_err !== 1'b1) begin n_err++; $display("FAIL seed0 seed_err: got %b expected 1", seed_err); end
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL seed0 out_valid: got %b expected 1", out_valid); end
        tick();
        seed_valid = 1; seed_in = 8'h3C;
        tick();
        seed_valid = 0;
        n_vec++; if (out_s !== 8'h3C) begin n_err++; $display("FAIL seed3c out_s: got %h expected 3c", out_s); end
        n_vec++; if (seed_err !== 1'b0) begin n_err++; $display("FAIL seed3c seed_err: got %b expected 0", seed_err); end
    endtask

    task automatic test_load_wins();
        rst = 1; tick(); rst = 0;
        en = 1; tick();
        seed_valid = 1; seed_in = 8'h55;
        tick();
        n_vec++; if (out_s !== 8'h55) begin n_err++; $display("FAIL loadwins out_s: got %h expected 55", out_s); end
        n_vec++; if (seed_ready !== 1'b0) begin n_err++; $display("FAIL loadwins seed_ready: got %b expected 0", seed_ready); end
        seed_valid = 0;
        tick();
        n_vec++; if (seed_ready !== 1'b1) begin n_err++; $display("FAIL loadwins seed_ready recover: got %b expected 1", seed_ready); end
        n_vec++; if (out_s !== m_s) begin n_err++; $display("FAIL loadwins step after load: got %h expected %h", out_s, m_s); end
        en = 0;
    endtask

    task automatic test_steps4();
        logic [7:0] exp4;
        rst = 1; tick(); rst = 0;
        exp4 = 8'h80;
        for (int k = 0; k < 4; k++) exp4 = model_shift(exp4);
        en4 = 1; tick(); en4 = 0;
        n_vec++; if (out_s4 !== exp4) begin n_err++; $display("FAIL steps4 out_s: got %h expected %h", out_s4, exp4); end
        n_vec++; if (out_valid4 !== 1'b1) begin n_err++; $display("FAIL steps4 out_valid: got %b expected 1", out_valid4); end
        tick();
        n_vec++; if (out_s4 !== m4_s) begin n_err++; $display("FAIL steps4 hold: got %h expected %h", out_s4, m4_s); end
    endtask

    task automatic test_hold_reset();
        logic [7:0] frozen;
        rst = 1; tick(); rst = 0;
        en = 1; tick(); tick(); tick();
        en = 0;
        frozen = m_s;
        for (int c = 0; c < 4; c++) begin
            tick();
            n_vec++; if (out_s !== frozen) begin n_err++; $display("FAIL hold out_s cycle %0d: got %h expected %h", c, out_s, frozen); end
            n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL hold out_valid cycle %0d: got %b expected 1", c, out_valid); end
        end
        en = 1; tick();
        rst = 1; seed_valid = 1; seed_in = 8'h5A;
        tick();
        rst = 0; seed_valid = 0; en = 0;
        n_vec++; if (out_s !== 8'h80) begin n_err++; $display("FAIL midreset out_s: got %h expected 80", out_s); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midreset out_valid: got %b expected 0", out_valid); end
        tick();
        n_vec++; if (out_s !== 8'h80) begin n_err++; $display("FAIL midreset discard: got %h expected 80", out_s); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst        = ($urandom_range(0, 63) == 0);
            en         = 1'($urandom_range(0, 1));
            seed_valid = ($urandom_range(0, 3) == 0);
            seed_in    = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            tick();
            n_vec++; if (out_s !== m_s) begin n_err++; $display("FAIL random out_s cycle %0d: got %h expected %h", c, out_s, m_s); end
            n_vec++; if (out_valid !== m_valid) begin n_err++; $display("FAIL random out_valid cycle %0d: got %b expected %b", c, out_valid, m_valid); end
            n_vec++; if (seed_ready !== m_ready) begin n_err++; $display("FAIL random seed_ready cycle %0d: got %b expected %b", c, seed_ready, m_ready); end
            n_vec++; if (seed_err !== m_err) begin n_err++; $display("FAIL random seed_err cycle %0d: got %b expected %b", c, seed_err, m_err); end
`ifdef LFSR_GEN_WRAP_DET_EN
            n_vec++; if (wrap !== m_wrap) begin n_err++; $display("FAIL random wrap cycle %0d: got %b expected %b", c, wrap, m_wrap); end
`endif
        end
        rst = 0; en = 0; seed_valid = 0;
    endtask

    initial begin
        test_reset();
        test_run5();
        test_wrap();
        test_seed_err();
        test_load_wins();
        test_steps4();
        test_hold_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
